instruction_replay_buffer: RTL and testbench
============================================

Name: instruction_replay_buffer

Overview:
- Single-clock store-and-forward buffer for instruction batches.
- Captures one batch terminated by `wr_last`, then streams it out with valid/ready one or more times (programmable replay count).
- Successor to the dual-clock batch buffer: adds write backpressure, per-batch replay, overflow truncation, abort, and occupancy reporting.
- Sits between the instruction decoder and the execution engines.

Parameters:
- INSTRUCTION_WIDTH, 16, bits per instruction.
- MAX_INSTRUCTIONS, 512, buffer depth in entries; power of two, ≥2. ADDR_WIDTH = $clog2(MAX_INSTRUCTIONS).
- REPLAY_WIDTH, 4, width of the replay count.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous; discards the current batch.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  buffer accepts a write beat.
- wr_last  in  1  final instruction of the batch.
- wr_data  in  INSTRUCTION_WIDTH  instruction.
- replay_count  in  REPLAY_WIDTH  extra passes; sampled on the `wr_last` handshake.
- rd_valid  out  1  output beat valid.
- rd_ready  in  1  consumer accepts the beat.
- rd_last  out  1  last instruction of the current pass.
- rd_final  out  1  last instruction of the final pass.
- rd_data  out  INSTRUCTION_WIDTH  instruction.
- batch_len  out  ADDR_WIDTH+1  entries in the stored batch.
- overflow  out  1  sticky; batch was truncated.

Behaviour:
- Reset (reset_n=0, async):
  - State FILL; write and read pointers 0; pass counter 0.
  - Outputs: wr_ready=1, rd_valid=0, rd_last=0, rd_final=0, rd_data=0, batch_len=0, overflow=0.
  - Reset mid-operation drops all data; no beat completes after reset assertion.
- States: FILL, PRIME, DRAIN.
- FILL:
  - wr_ready=1; rd_valid=0.
  - Each wr_valid&&wr_ready writes wr_data to ram[wr_ptr] and increments wr_ptr.
  - On a handshake with wr_last=1:
    - batch_len <= wr_ptr+1.
    - pass counter <= replay_count (total passes = replay_count+1; 0 means one pass).
    - wr_ready drops the next cycle; go to PRIME.
  - A handshake with wr_last=0 while wr_ptr==MAX_INSTRUCTIONS-1:
    - Treated as last; overflow <= 1.
    - batch_len=MAX_INSTRUCTIONS; pass counter <= replay_count; go to PRIME.
- PRIME:
  - One cycle; RAM read of entry 0 issued; go to DRAIN.
  - First rd_valid is asserted exactly 2 cycles after the last write handshake.
- DRAIN:
  - wr_ready=0. Output register holds {rd_data, rd_last, rd_final}.
  - Values are stable while rd_valid && !rd_ready; one-entry prefetch/skid keeps full throughput, one beat per cycle, with rd_ready held high.
  - rd_last=1 when read index == batch_len-1.
  - rd_final = rd_last && pass counter==0.
  - Handshake on a beat with rd_last=1 and pass counter≠0: decrement pass counter; read index wraps to 0 with no bubble.
  - Handshake with rd_final=1:
    - Next cycle: rd_valid=0, wr_ready=1, wr_ptr=0, state FILL.
    - batch_len and overflow hold until the next batch's first write, which clears overflow.
- abort=1 (any state):
  - Next cycle: FILL, pointers 0, rd_valid=0, wr_ready=1, overflow=0.
  - abort has priority over a simultaneous handshake; that beat is not counted.
- Pointer arithmetic is modulo 2**ADDR_WIDTH. batch_len is one bit wider so that MAX_INSTRUCTIONS is representable.
- rd_ready asserted while rd_valid=0 has no effect.
- RAM inference: single write port, single registered read port; no reset on the array.

Test Plan:
- MAX=8, write 3 beats A,B,C (C with last), replay_count=0, rd_ready=1:
  - Outputs A,B,C on consecutive cycles, first 2 cycles after C.
  - rd_last and rd_final both high on C; batch_len=3; wr_ready=1 the cycle after.
- Write X,Y (last), replay_count=2:
  - 6 beats X,Y,X,Y,X,Y with no bubbles.
  - rd_last on each Y; rd_final only on the 3rd Y.
- Random rd_ready (50%) over a 5-entry batch, replay 1:
  - Exactly 10 beats in order.
  - rd_data/rd_last stable during every stall; no beat dropped or duplicated.
- MAX=4, write 6 beats with no wr_last:
  - Only 4 beats accepted; overflow=1, batch_len=4.
  - wr_ready=0 from the 5th beat on; readout of 4 beats ends with rd_final on the 4th.
  - Next batch's first write clears overflow.
- Single-entry batch, replay_count=15:
  - 16 beats of the same word, rd_last on every beat, rd_final only on the 16th.
- reset_n pulsed low mid-DRAIN, then separately abort mid-FILL:
  - Immediate rd_valid=0, wr_ready=1.
  - New 2-entry batch reads back correctly from index 0.

Source files
------------

// File: rtl/instruction_replay_buffer.sv
// rtl/instruction_replay_buffer.sv - store-and-forward instruction batch buffer with programmable replay
// Captures one batch, then streams it replay_count+1 times; the RAM read register doubles as the output register.
module instruction_replay_buffer #(
   parameter int INSTRUCTION_WIDTH = 16,
   parameter int MAX_INSTRUCTIONS  = 512,
   parameter int REPLAY_WIDTH      = 4,
   localparam int ADDR_WIDTH       = $clog2(MAX_INSTRUCTIONS)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         abort,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic                         wr_last,
   input  logic [INSTRUCTION_WIDTH-1:0] wr_data,
   input  logic [REPLAY_WIDTH-1:0]      replay_count,
   output logic                         rd_valid,
   input  logic                         rd_ready,
   output logic                         rd_last,
   output logic                         rd_final,
   output logic [INSTRUCTION_WIDTH-1:0] rd_data,
   output logic [ADDR_WIDTH:0]          batch_len,
   output logic                         overflow
);

   localparam logic [1:0] FILL  = 2'd0;
   localparam logic [1:0] PRIME = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_INSTRUCTIONS - 1);

   logic [1:0]                   state;
   logic [ADDR_WIDTH-1:0]        wr_ptr;
   logic [ADDR_WIDTH-1:0]        rd_idx;
   logic [ADDR_WIDTH-1:0]        next_idx;
   logic [REPLAY_WIDTH-1:0]      pass_cnt;
   logic [REPLAY_WIDTH-1:0]      pass_next;
   logic [INSTRUCTION_WIDTH-1:0] ram [MAX_INSTRUCTIONS];
   logic                         wr_fire;
   logic                         wr_end;
   logic                         rd_fire;
   logic                         rd_en;
   logic                         last_next;
   logic                         final_next;

   assign wr_ready = (state == FILL);
   assign wr_fire  = wr_valid && wr_ready && !abort;
   assign wr_end   = wr_fire && (wr_last || (wr_ptr == LAST_ADDR));
   assign rd_fire  = (state == DRAIN) && rd_valid && rd_ready && !abort;

   // In PRIME this yields index 0 with the pass counter untouched; in DRAIN it is the beat after the current one.
   always_comb begin
      next_idx  = '0;
      pass_next = pass_cnt;
      if (state == DRAIN) begin
         if (rd_last) begin
            pass_next = pass_cnt - REPLAY_WIDTH'(1);
         end else begin
            next_idx = rd_idx + ADDR_WIDTH'(1);
         end
      end
   end

   assign last_next  = ({1'b0, next_idx} == (batch_len - (ADDR_WIDTH+1)'(1)));
   assign final_next = last_next && (pass_next == '0);
   assign rd_en      = !abort && ((state == PRIME) || (rd_fire && !rd_final));

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         ram[wr_ptr] <= wr_data;
      end
   end

   // Read register only advances on a handshake, so it holds the presented beat during a stall.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= ram[next_idx];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= FILL;
         wr_ptr    <= '0;
         rd_idx    <= '0;
         pass_cnt  <= '0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rd_final  <= 1'b0;
         batch_len <= '0;
         overflow  <= 1'b0;
      end else if (abort) begin
         state    <= FILL;
         wr_ptr   <= '0;
         rd_idx   <= '0;
         pass_cnt <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_final <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (wr_fire) begin
                  wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                  if (wr_ptr == '0) begin
                     overflow <= 1'b0;
                  end
                  if (wr_end) begin
                     wr_ptr    <= '0;
                     batch_len <= {1'b0, wr_ptr} + (ADDR_WIDTH+1)'(1);
                     pass_cnt  <= replay_count;
                     overflow  <= !wr_last && (wr_ptr == LAST_ADDR);
                     state     <= PRIME;
                  end
               end
            end
            PRIME: begin
               state    <= DRAIN;
               rd_valid <= 1'b1;
               rd_idx   <= next_idx;
               rd_last  <= last_next;
               rd_final <= final_next;
            end
            DRAIN: begin
               if (rd_fire) begin
                  if (rd_final) begin
                     state    <= FILL;
                     wr_ptr   <= '0;
                     rd_valid <= 1'b0;
                     rd_last  <= 1'b0;
                     rd_final <= 1'b0;
                  end else begin
                     rd_idx   <= next_idx;
                     pass_cnt <= pass_next;
                     rd_last  <= last_next;
                     rd_final <= final_next;
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_replay_buffer.sv
// tb/tb_instruction_replay_buffer.sv - self-checking bench for instruction_replay_buffer
module tb_instruction_replay_buffer;

   localparam int W   = 16;
   localparam int MAX = 8;
   localparam int AW  = $clog2(MAX);
   localparam int RW  = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          abort;
   logic          wr_valid;
   logic          wr_ready;
   logic          wr_last;
   logic [W-1:0]  wr_data;
   logic [RW-1:0] replay_count;
   logic          rd_valid;
   logic          rd_ready;
   logic          rd_last;
   logic          rd_final;
   logic [W-1:0]  rd_data;
   logic [AW:0]   batch_len;
   logic          overflow;

   instruction_replay_buffer #(
      .INSTRUCTION_WIDTH(W),
      .MAX_INSTRUCTIONS (MAX),
      .REPLAY_WIDTH     (RW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .abort       (abort),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_last     (wr_last),
      .wr_data     (wr_data),
      .replay_count(replay_count),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .rd_last     (rd_last),
      .rd_final    (rd_final),
      .rd_data     (rd_data),
      .batch_len   (batch_len),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int len;
      int rc;
      bit no_last;
      bit rand_ready;
      int exp_beats;
      int exp_len;
      bit exp_ov;
   } vec_t;

   typedef struct {
      logic [W-1:0] data;
      bit           last;
      bit           fin;
   } beat_t;

   int           checks = 0;
   int           errors = 0;
   beat_t        exp_q[$];
   logic [W-1:0] words[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Writes a batch, builds the expected beat stream and checks the PRIME cycle.
   task automatic write_batch(input int len, input int rc, input bit no_last,
                              input int exp_len, input bit exp_ov);
      logic [W-1:0] d;
      words.delete();
      for (int k = 0; k < exp_len; k++) begin
         @(negedge clk);
         d            = W'($urandom);
         wr_valid     = 1'b1;
         wr_data      = d;
         wr_last      = !no_last && (k == len - 1);
         replay_count = RW'(rc);
         chk("wr_ready_fill", 32'(wr_ready), 32'(1));
         if (k > 0) chk("overflow_clear", 32'(overflow), 32'(0));
         words.push_back(d);
      end
      for (int p = 0; p <= rc; p++) begin
         for (int i = 0; i < exp_len; i++) begin
            exp_q.push_back('{data: words[i], last: (i == exp_len - 1),
                              fin: (i == exp_len - 1) && (p == rc)});
         end
      end
      @(negedge clk);
      wr_valid     = no_last;
      wr_last      = 1'b0;
      wr_data      = W'($urandom);
      replay_count = RW'($urandom);
      chk("wr_ready_prime", 32'(wr_ready), 32'(0));
      chk("rd_valid_prime", 32'(rd_valid), 32'(0));
      chk("overflow_set", 32'(overflow), 32'(exp_ov));
      chk("batch_len", 32'(batch_len), 32'(exp_len));
   endtask

   task automatic read_batch(input bit rand_ready, input int stop_after, output int beats);
      bit           stalled = 1'b0;
      bit           done = 1'b0;
      int           cyc = 0;
      logic [W-1:0] held_d = '0;
      logic         held_l = 1'b0;
      beat_t        e;
      beats = 0;
      while (!done && cyc < 400 && beats < stop_after) begin
         @(negedge clk);
         if (cyc == 0) chk("first_valid_latency", 32'(rd_valid), 32'(1));
         cyc++;
         rd_ready = rand_ready ? 1'($urandom) : 1'b1;
         chk("wr_ready_drain", 32'(wr_ready), 32'(0));
         chk("no_bubble", 32'(rd_valid), 32'(1));
         if (stalled) begin
            chk("stall_data", 32'(rd_data), 32'(held_d));
            chk("stall_last", 32'(rd_last), 32'(held_l));
         end
         if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 32'(0), 32'(1));
            end else begin
               e = exp_q.pop_front();
               chk("rd_data", 32'(rd_data), 32'(e.data));
               chk("rd_last", 32'(rd_last), 32'(e.last));
               chk("rd_final", 32'(rd_final), 32'(e.fin));
               done = e.fin;
            end
            beats++;
         end
         stalled = rd_valid && !rd_ready;
         held_d  = rd_data;
         held_l  = rd_last;
      end
      if (!done && beats < stop_after) chk("read_timeout", 32'(0), 32'(1));
   endtask

   task automatic run_vector(input vec_t v);
      int beats;
      write_batch(v.len, v.rc, v.no_last, v.exp_len, v.exp_ov);
      read_batch(v.rand_ready, 1 << 30, beats);
      chk("beat_count", 32'(beats), 32'(v.exp_beats));
      chk("model_empty", 32'(exp_q.size()), 32'(0));
      @(negedge clk);
      wr_valid = 1'b0;
      chk("idle_rd_valid", 32'(rd_valid), 32'(0));
      chk("idle_wr_ready", 32'(wr_ready), 32'(1));
      chk("idle_batch_len", 32'(batch_len), 32'(v.exp_len));
      chk("idle_overflow", 32'(overflow), 32'(v.exp_ov));
      exp_q.delete();
   endtask

   initial begin
      vec_t vecs[$];
      int   n;
      int   r;
      int   beats;

      reset_n = 1'b0; abort = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
      wr_data = '0; replay_count = '0; rd_ready = 1'b0;
      #12;
      chk("rst_wr_ready", 32'(wr_ready), 32'(1));
      chk("rst_rd_valid", 32'(rd_valid), 32'(0));
      chk("rst_rd_last", 32'(rd_last), 32'(0));
      chk("rst_rd_final", 32'(rd_final), 32'(0));
      chk("rst_rd_data", 32'(rd_data), 32'(0));
      chk("rst_batch_len", 32'(batch_len), 32'(0));
      chk("rst_overflow", 32'(overflow), 32'(0));
      @(negedge clk);
      reset_n = 1'b1;

      vecs.push_back('{3, 0, 1'b0, 1'b0, 3, 3, 1'b0});
      vecs.push_back('{2, 2, 1'b0, 1'b0, 6, 2, 1'b0});
      vecs.push_back('{5, 1, 1'b0, 1'b1, 10, 5, 1'b0});
      vecs.push_back('{10, 0, 1'b1, 1'b0, 8, 8, 1'b1});
      vecs.push_back('{6, 1, 1'b0, 1'b1, 12, 6, 1'b0});
      vecs.push_back('{1, 15, 1'b0, 1'b0, 16, 1, 1'b0});
      vecs.push_back('{8, 1, 1'b0, 1'b0, 16, 8, 1'b0});
      for (int i = 0; i < 6; i++) begin
         n = $urandom_range(1, MAX);
         r = $urandom_range(0, 3);
         vecs.push_back('{n, r, 1'b0, 1'($urandom), (r + 1) * n, n, 1'b0});
      end
      foreach (vecs[i]) run_vector(vecs[i]);

      // Reset pulsed mid-DRAIN.
      write_batch(4, 3, 1'b0, 4, 1'b0);
      read_batch(1'b0, 5, beats);
      reset_n = 1'b0;
      #1;
      chk("rstmid_rd_valid", 32'(rd_valid), 32'(0));
      chk("rstmid_wr_ready", 32'(wr_ready), 32'(1));
      chk("rstmid_rd_data", 32'(rd_data), 32'(0));
      chk("rstmid_batch_len", 32'(batch_len), 32'(0));
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      run_vector('{2, 0, 1'b0, 1'b0, 2, 2, 1'b0});

      // Abort mid-FILL, colliding with a last-beat handshake.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         wr_valid = 1'b1; wr_last = 1'b0; wr_data = W'($urandom);
      end
      @(negedge clk);
      abort = 1'b1; wr_last = 1'b1; wr_data = W'($urandom);
      @(negedge clk);
      abort = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
      chk("abort_fill_wr_ready", 32'(wr_ready), 32'(1));
      chk("abort_fill_rd_valid", 32'(rd_valid), 32'(0));
      run_vector('{2, 1, 1'b0, 1'b1, 4, 2, 1'b0});

      // Abort mid-DRAIN of an overflowed batch clears the sticky flag.
      write_batch(10, 0, 1'b1, 8, 1'b1);
      read_batch(1'b0, 3, beats);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; wr_valid = 1'b0;
      chk("abort_drain_overflow", 32'(overflow), 32'(0));
      chk("abort_drain_rd_valid", 32'(rd_valid), 32'(0));
      chk("abort_drain_wr_ready", 32'(wr_ready), 32'(1));
      exp_q.delete();
      run_vector('{3, 2, 1'b0, 1'b1, 9, 3, 1'b0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
